// File: rtl/spike_class_decoder_pkg.sv
// Shared constants, state encoding and helpers for the spike class decoder.
package spike_class_decoder_pkg;

  localparam int unsigned N_OUT = 10;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; used to validate index widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_class_decoder_if.sv
// Spike stream in, classification result out, plus status flags.
interface spike_class_decoder_if;
  import spike_class_decoder_pkg::*;

  logic             spike_valid;
  logic [N_OUT-1:0] spike;
  logic             frame_end;
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] class_id;
  logic [CNT_W-1:0] max_count;
  logic             busy;
  logic             overrun;

  // Environment side: drives spikes and accepts results.
  modport master (
    output spike_valid, spike, frame_end, result_ready,
    input  result_valid, class_id, max_count, busy, overrun
  );

  // Decoder side.
  modport slave (
    input  spike_valid, spike, frame_end, result_ready,
    output result_valid, class_id, max_count, busy, overrun
  );

endinterface

// File: rtl/spike_class_decoder_counter_bank.sv
// Bank of saturating per-neuron spike counters with a read mux by index.
module spike_counter_bank
  import spike_class_decoder_pkg::*;
#(
  parameter int unsigned NOut = N_OUT,
  parameter int unsigned CntW = CNT_W,
  parameter int unsigned IdxW = IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic [NOut-1:0] spike,
  input  logic            clear,
  input  logic [IdxW-1:0] rd_idx,
  output logic [CntW-1:0] rd_cnt
);

  if (clog2(NOut) > IdxW) begin : g_idx_w_check
    $error("IdxW too narrow to address every counter");
  end

  logic [CntW-1:0] cnt_q [NOut];

  // Count spikes per neuron, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NOut; k++) cnt_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NOut; k++) cnt_q[k] <= '0;
    end else if (inc_en) begin
      for (int k = 0; k < NOut; k++) begin
        if (spike[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CntW'(1);
      end
    end
  end

  // Read mux; out-of-range indices read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int k = 0; k < NOut; k++) begin
      if (rd_idx == IdxW'(k)) rd_cnt = cnt_q[k];
    end
  end

endmodule

// File: rtl/spike_class_decoder.sv
// Accumulates output-layer spikes per image, then scans for the argmax class
// and offers it through a valid/ready handshake.
module spike_class_decoder
  import spike_class_decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  spike_class_decoder_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] class_id_q, class_id_d;
  logic [CNT_W-1:0] max_count_q, max_count_d;
  logic             overrun_q, overrun_d;

  logic             in_accum;
  logic             handshake;
  logic             last_idx;
  logic             better;
  logic [CNT_W-1:0] rd_cnt;

  assign in_accum  = (state_q == ST_ACCUM);
  assign handshake = (state_q == ST_HOLD) && bus.result_ready;
  assign last_idx  = (scan_idx_q == IDX_W'(N_OUT - 1));
  // Strict compare keeps the lowest index on ties.
  assign better    = (rd_cnt > best_cnt_q);

  spike_counter_bank #(
    .NOut (N_OUT),
    .CntW (CNT_W),
    .IdxW (IDX_W)
  ) u_counter_bank (
    .clk    (clk),
    .rst    (rst),
    .inc_en (in_accum && bus.spike_valid),
    .spike  (bus.spike),
    .clear  (handshake),
    .rd_idx (scan_idx_q),
    .rd_cnt (rd_cnt)
  );

  // Next-state: accumulate, scan one counter per cycle, hold until accepted.
  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    class_id_d  = class_id_q;
    max_count_d = max_count_q;
    // Stream events outside ACCUM are dropped but remembered.
    overrun_d   = overrun_q || (!in_accum && (bus.spike_valid || bus.frame_end));

    case (state_q)
      ST_ACCUM: begin
        if (bus.frame_end) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end
      end
      ST_SCAN: begin
        if (better) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = rd_cnt;
        end
        if (last_idx) begin
          state_d     = ST_HOLD;
          class_id_d  = better ? scan_idx_q : best_idx_q;
          max_count_d = better ? rd_cnt : best_cnt_q;
          scan_idx_d  = '0;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.result_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACCUM;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      class_id_q  <= '0;
      max_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      class_id_q  <= class_id_d;
      max_count_q <= max_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.result_valid = (state_q == ST_HOLD);
  assign bus.busy         = (state_q == ST_SCAN) || (state_q == ST_HOLD);
  assign bus.class_id     = class_id_q;
  assign bus.max_count    = max_count_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_spike_class_decoder.sv
// Directed bench for spike_class_decoder.
module tb_spike_class_decoder;
  import spike_class_decoder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spike_class_decoder_if bus ();

  spike_class_decoder dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus, launched on the falling edge.
  task automatic step(input logic [N_OUT-1:0] v, input logic sv, input logic fe);
    bus.spike       = v;
    bus.spike_valid = sv;
    bus.frame_end   = fe;
    @(negedge clk);
    bus.spike       = '0;
    bus.spike_valid = 1'b0;
    bus.frame_end   = 1'b0;
  endtask

  // Wait for result_valid; lat counts cycles since the frame_end cycle.
  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept(input string name);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept valid=%0b busy=%0b want 0 0", name, bus.result_valid, bus.busy);
    end
  endtask

  task automatic expect_result(input string name, input int cls, input int cnt);
    int lat;
    wait_result(lat);
    checks++;
    if (bus.result_valid !== 1'b1 || bus.class_id !== IDX_W'(cls) ||
        bus.max_count !== CNT_W'(cnt)) begin
      errors++;
      $display("FAIL %s valid=%0b class=%0d count=%0d want 1 %0d %0d",
               name, bus.result_valid, bus.class_id, bus.max_count, cls, cnt);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.class_id !== '0 || bus.max_count !== '0 ||
        bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset valid=%0b class=%0d count=%0d busy=%0b ovr=%0b want all 0",
               bus.result_valid, bus.class_id, bus.max_count, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_basic;
    int lat;
    repeat (3) step(10'b0000001000, 1'b1, 1'b0);
    repeat (2) step(10'b0000001001, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_scan_busy busy=%0b valid=%0b want 1 0", bus.busy, bus.result_valid);
    end
    wait_result(lat);
    checks++;
    if (lat != 11) begin
      errors++;
      $display("FAIL basic_latency got %0d want 11", lat);
    end
    checks++;
    if (bus.class_id !== 4'd3 || bus.max_count !== 8'd5) begin
      errors++;
      $display("FAIL basic_argmax class=%0d count=%0d want 3 5", bus.class_id, bus.max_count);
    end
    accept("basic");
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_overrun got %0b want 0", bus.overrun);
    end
  endtask

  task automatic test_tie_empty;
    repeat (4) step(10'b0010000100, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    expect_result("tie", 2, 4);
    accept("tie");
    step('0, 1'b0, 1'b1);
    expect_result("empty", 0, 0);
    accept("empty");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      step((i < 255) ? 10'b1000000001 : 10'b1000000000, 1'b1, 1'b0);
    end
    step('0, 1'b0, 1'b1);
    expect_result("saturation", 0, 255);
    accept("saturation");
  endtask

  task automatic test_same_cycle;
    step(10'b0001000000, 1'b1, 1'b0);
    step(10'b0001000000, 1'b1, 1'b1);
    expect_result("same_cycle", 6, 2);
    accept("same_cycle");
  endtask

  task automatic test_backpressure;
    int bad;
    repeat (2) step(10'b0000000010, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    expect_result("bp_first", 1, 2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step('1, 1'b1, i[0]);
      if (bus.result_valid !== 1'b1 || bus.class_id !== 4'd1 || bus.max_count !== 8'd2 ||
          bus.overrun !== 1'b1 || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold_stable bad_cycles=%0d want 0 (last class=%0d count=%0d ovr=%0b)",
               bad, bus.class_id, bus.max_count, bus.overrun);
    end
    accept("bp");
    repeat (3) step(10'b0000100000, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    expect_result("bp_next", 5, 3);
    accept("bp_next");
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun_sticky got %0b want 1", bus.overrun);
    end
  endtask

  task automatic test_midreset;
    int seen;
    repeat (2) step(10'b0000010000, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_scan busy=%0b want 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.class_id !== '0 || bus.max_count !== '0 ||
        bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear valid=%0b class=%0d count=%0d busy=%0b ovr=%0b want all 0",
               bus.result_valid, bus.class_id, bus.max_count, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_no_result active_cycles=%0d want 0", seen);
    end
    // Counters must have been cleared by the reset as well.
    step('0, 1'b0, 1'b1);
    expect_result("midreset_after", 0, 0);
    accept("midreset_after");
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.spike        = '0;
    bus.spike_valid  = 1'b0;
    bus.frame_end    = 1'b0;
    bus.result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tie_empty();
    test_saturation();
    test_same_cycle();
    test_backpressure();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
